// File: rtl/outer_ebi_ctrl.sv
// EBI link controller: sequences inbound frames into the transceiver receive buffer,
// hands them to the local buffer, and drives outbound frames including write ACKs.
module outer_ebi_ctrl #(
   parameter int EBI_WIDTH      = 16,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       trx_rcv_start,
   input  logic       trx_rcv_done,
   input  logic       trx_send_done,
   input  logic [3:0] rx_opcode,
   output logic       is_counter_reload,
   output logic       is_counter_ena,
   output logic       is_rd_rcv,
   output logic       is_send_mode,
   output logic [3:0] opcode,
   output logic       req_valid,
   output logic [1:0] req_type,
   input  logic       req_ready,
   input  logic       tx_valid,
   input  logic [3:0] tx_opcode,
   output logic       tx_ready,
   output logic       err_timeout,
   output logic       err_opcode
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] HDR     = 3'd1;
   localparam logic [2:0] BODY    = 3'd2;
   localparam logic [2:0] LAST    = 3'd3;
   localparam logic [2:0] DELIVER = 3'd4;
   localparam logic [2:0] S_LOAD  = 3'd5;
   localparam logic [2:0] SEND    = 3'd6;
   localparam logic [2:0] TURN    = 3'd7;

   localparam logic [3:0]  OP_IDLE   = 4'h5;
   localparam logic [3:0]  OP_ACK    = 4'hF;
   localparam logic [3:0]  RX_MASK   = (EBI_WIDTH >= 4) ? 4'hF : 4'((1 << EBI_WIDTH) - 1);
   localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES - 1);

   logic [2:0]  state, state_n;
   logic [15:0] tmo_cnt, tmo_cnt_n;
   logic [3:0]  opcode_n, rx_code;
   logic [1:0]  req_type_n;
   logic        tx_ready_n, err_timeout_n, err_opcode_n;
   logic        timed, tmo_hit;
   logic [4:0]  ctrl_n;

   // Controls are a pure function of the state being entered; {reload, ena, rd_rcv, send, req_valid}
   function automatic logic [4:0] ctrl_of(input logic [2:0] s);
      case (s)
         HDR:     ctrl_of = 5'b10000;
         BODY:    ctrl_of = 5'b01100;
         LAST:    ctrl_of = 5'b01100;
         DELIVER: ctrl_of = 5'b00001;
         S_LOAD:  ctrl_of = 5'b10010;
         SEND:    ctrl_of = 5'b01010;
         default: ctrl_of = 5'b00000;
      endcase
   endfunction

   assign rx_code = rx_opcode & RX_MASK;
   assign timed   = (state == HDR) || (state == BODY) || (state == SEND);
   assign tmo_hit = timed && (tmo_cnt >= TMO_LIMIT);

   always_comb begin
      state_n       = state;
      opcode_n      = opcode;
      req_type_n    = req_type;
      tx_ready_n    = 1'b0;
      err_timeout_n = 1'b0;
      err_opcode_n  = 1'b0;
      case (state)
         IDLE: begin
            if (trx_rcv_start) begin
               state_n = HDR;
            end else if (tx_valid) begin
               tx_ready_n = 1'b1;
               if (tx_opcode == 4'd7 || tx_opcode == 4'd6) begin
                  opcode_n = tx_opcode;
                  state_n  = S_LOAD;
               end else begin
                  err_opcode_n = 1'b1;
               end
            end
         end
         HDR: begin
            state_n = BODY;
            case (rx_code)
               4'd0:       req_type_n = 2'd0;
               4'd1:       req_type_n = 2'd1;
               4'd2:       req_type_n = 2'd2;
               4'd3, 4'd4: req_type_n = 2'd3;
               default: begin
                  err_opcode_n = 1'b1;
                  state_n      = IDLE;
               end
            endcase
         end
         BODY: begin
            if (trx_rcv_done) begin
               state_n = LAST;
            end else if (tmo_hit) begin
               err_timeout_n = 1'b1;
               state_n       = IDLE;
            end
         end
         LAST: state_n = DELIVER;
         DELIVER: begin
            if (req_ready) begin
               if (req_type == 2'd1 || req_type == 2'd2) begin
                  opcode_n = OP_ACK;
                  state_n  = S_LOAD;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         S_LOAD: state_n = SEND;
         SEND: begin
            if (trx_send_done) begin
               opcode_n = OP_IDLE;
               state_n  = TURN;
            end else if (tmo_hit) begin
               opcode_n      = OP_IDLE;
               err_timeout_n = 1'b1;
               state_n       = IDLE;
            end
         end
         default: begin
            opcode_n = OP_IDLE;
            state_n  = IDLE;
         end
      endcase

      // Counter restarts on every state change and saturates rather than wrapping
      if (state_n != state)
         tmo_cnt_n = 16'd0;
      else if (timed && tmo_cnt != 16'hFFFF)
         tmo_cnt_n = tmo_cnt + 16'd1;
      else
         tmo_cnt_n = tmo_cnt;

      ctrl_n = ctrl_of(state_n);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state             <= IDLE;
         tmo_cnt           <= 16'd0;
         opcode            <= OP_IDLE;
         req_type          <= 2'd0;
         tx_ready          <= 1'b0;
         err_timeout       <= 1'b0;
         err_opcode        <= 1'b0;
         is_counter_reload <= 1'b0;
         is_counter_ena    <= 1'b0;
         is_rd_rcv         <= 1'b0;
         is_send_mode      <= 1'b0;
         req_valid         <= 1'b0;
      end else begin
         state             <= state_n;
         tmo_cnt           <= tmo_cnt_n;
         opcode            <= opcode_n;
         req_type          <= req_type_n;
         tx_ready          <= tx_ready_n;
         err_timeout       <= err_timeout_n;
         err_opcode        <= err_opcode_n;
         is_counter_reload <= ctrl_n[4];
         is_counter_ena    <= ctrl_n[3];
         is_rd_rcv         <= ctrl_n[2];
         is_send_mode      <= ctrl_n[1];
         req_valid         <= ctrl_n[0];
      end
   end

endmodule
